// File: rtl/comb_fixed_point_sin.sv
// Registered fixed-point sine.
//   clk      : rising-edge clock
//   rstn     : asynchronous active-low reset, clears out/upflow/downflow
//   in       : signed angle in radians, value = signed(in) / 2^WIF
//   out      : signed sin(in), value = signed(out) / 2^WOF, registered
//   upflow   : rounded result above the most positive output code
//   downflow : rounded result below the most negative output code
// Combinational core (range reduction, Horner Taylor series, rounding,
// overflow handling) feeds one output register stage.
module comb_fixed_point_sin #(
    parameter int WII   = 8,
    parameter int WIF   = 8,
    parameter int WOI   = 8,
    parameter int WOF   = 8,
    parameter int ROOF  = 1,
    parameter int ROUND = 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [WII+WIF-1:0] in,
    output logic [WOI+WOF-1:0] out,
    output logic               upflow,
    output logic               downflow
);

    localparam int NI  = WII + WIF;
    localparam int NO  = WOI + WOF;
    localparam int IFW = WOF + 12;          // internal fraction bits (guard bits)
    localparam int SH  = IFW - WOF;
    localparam int CW  = IFW + 3;           // sign + 2 integer bits: covers r, r^2, partials
    localparam int PW  = 2 * CW;
    localparam int CF  = WII + WOF + 12;    // fraction bits of the 2/pi constant
    localparam int QW  = NI + CF + 1;
    localparam int FF  = IFW + 2;           // quarter-turn fraction bits kept
    localparam int QTW = FF + 2;
    localparam int RPW = 2 * FF + 2;
    localparam int RW  = NO + 4;

    localparam logic [95:0] TWO_OVER_PI_LIT = 96'hA2F9836E_4E441529_FC2757D1;
    localparam logic [96:0] HALF_PI_LIT     = 97'h1_921FB544_42D18469_898CC517;

    localparam logic signed [CF:0] K_TWO_OVER_PI = {1'b0, TWO_OVER_PI_LIT[95 -: CF]};
    localparam logic        [FF:0] K_HALF_PI     = HALF_PI_LIT[96 -: FF+1];

    // Taylor coefficients (-1)^k / (2k+1)! with IFW fraction bits
    localparam real SC = 2.0 ** IFW;
    localparam logic signed [CW-1:0] C1  = CW'(1) <<< IFW;
    localparam logic signed [CW-1:0] C3  = -CW'($rtoi(SC / 6.0 + 0.5));
    localparam logic signed [CW-1:0] C5  =  CW'($rtoi(SC / 120.0 + 0.5));
    localparam logic signed [CW-1:0] C7  = -CW'($rtoi(SC / 5040.0 + 0.5));
    localparam logic signed [CW-1:0] C9  =  CW'($rtoi(SC / 362880.0 + 0.5));
    localparam logic signed [CW-1:0] C11 = -CW'($rtoi(SC / 39916800.0 + 0.5));
    localparam logic signed [CW-1:0] C13 =  CW'($rtoi(SC / 6227020800.0 + 0.5));

    // Truncation mode subtracts 1/8 output LSB, larger than the core's
    // worst-case positive error, so the floored result never exceeds sin(x).
    localparam logic signed [CW-1:0] RND_ADJ = (ROUND != 0) ? (CW'(1) <<< (SH - 1))
                                                            : -(CW'(1) <<< (SH - 3));

    localparam logic signed [RW-1:0] MAX_V = {{(RW-NO+1){1'b0}}, {(NO-1){1'b1}}};
    localparam logic signed [RW-1:0] MIN_V = {{(RW-NO+1){1'b1}}, {(NO-1){1'b0}}};

    // Fixed-point multiply, result floored back to IFW fraction bits
    function automatic logic signed [CW-1:0] mul_fx(input logic signed [CW-1:0] a,
                                                    input logic signed [CW-1:0] b);
        logic signed [PW-1:0] prod;
        prod = PW'(a) * PW'(b);
        return CW'(prod >>> IFW);
    endfunction

    logic signed [QW-1:0]  q;
    logic        [QTW-1:0] qt;
    logic        [FF:0]    f;
    logic        [RPW-1:0] rp;
    logic signed [CW-1:0]  r;
    logic signed [CW-1:0]  z;
    logic signed [CW-1:0]  p;
    logic signed [CW-1:0]  s;
    logic signed [CW-1:0]  adj;
    logic signed [RW-1:0]  rv;
    logic                  up_c;
    logic                  dn_c;
    logic        [NO-1:0]  out_c;

    always_comb begin
        // Scale to quarter turns: the two's-complement integer part mod 4 is
        // the quadrant and the fraction is the position inside it, so the
        // modulo-2*pi reduction is exact for every input, including the most
        // negative one, without any subtract-and-compare steps.
        q  = QW'($signed(in)) * QW'(K_TWO_OVER_PI);
        qt = QTW'(q >>> (WIF + CF - FF));

        // Odd quadrants use sin(pi - x) = sin(x): mirror the fraction
        f = {1'b0, qt[FF-1:0]};
        if (qt[FF]) begin
            f = {1'b1, {FF{1'b0}}} - f;
        end

        // Back to radians in [0, pi/2]
        rp = RPW'(f) * RPW'(K_HALF_PI);
        r  = CW'(rp >> (2 * FF - IFW));

        z = mul_fx(r, r);
        p = C13;
        p = mul_fx(p, z) + C11;
        p = mul_fx(p, z) + C9;
        p = mul_fx(p, z) + C7;
        p = mul_fx(p, z) + C5;
        p = mul_fx(p, z) + C3;
        p = mul_fx(p, z) + C1;
        s = mul_fx(r, p);

        // Upper half-turn uses sin(-x) = -sin(x)
        if (qt[FF+1]) begin
            s = -s;
        end

        adj  = s + RND_ADJ;
        rv   = RW'(adj >>> SH);
        up_c = rv > MAX_V;
        dn_c = rv < MIN_V;

        if (ROOF != 0 && up_c) begin
            out_c = MAX_V[NO-1:0];
        end else if (ROOF != 0 && dn_c) begin
            out_c = MIN_V[NO-1:0];
        end else begin
            out_c = rv[NO-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out      <= '0;
            upflow   <= 1'b0;
            downflow <= 1'b0;
        end else begin
            out      <= out_c;
            upflow   <= up_c;
            downflow <= dn_c;
        end
    end

endmodule

// File: tb/tb_comb_fixed_point_sin.sv
module tb_comb_fixed_point_sin;

    logic        clk  = 1'b0;
    logic        rstn = 1'b1;
    logic [15:0] in   = '0;

    logic [13:0] out_r;
    logic        up_r, dn_r;
    logic [13:0] out_t;
    logic        up_t, dn_t;
    logic [12:0] out_s;
    logic        up_s, dn_s;
    logic [12:0] out_w;
    logic        up_w, dn_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Reference configuration: round to nearest, saturate
    comb_fixed_point_sin #(.WII(4), .WIF(12), .WOI(2), .WOF(12), .ROOF(1), .ROUND(1)) u_rnd (
        .clk(clk), .rstn(rstn), .in(in), .out(out_r), .upflow(up_r), .downflow(dn_r));

    // Truncating variant
    comb_fixed_point_sin #(.WII(4), .WIF(12), .WOI(2), .WOF(12), .ROOF(1), .ROUND(0)) u_trn (
        .clk(clk), .rstn(rstn), .in(in), .out(out_t), .upflow(up_t), .downflow(dn_t));

    // Single integer bit, saturating
    comb_fixed_point_sin #(.WII(4), .WIF(12), .WOI(1), .WOF(12), .ROOF(1), .ROUND(1)) u_sat (
        .clk(clk), .rstn(rstn), .in(in), .out(out_s), .upflow(up_s), .downflow(dn_s));

    // Single integer bit, wrapping
    comb_fixed_point_sin #(.WII(4), .WIF(12), .WOI(1), .WOF(12), .ROOF(0), .ROUND(1)) u_wrp (
        .clk(clk), .rstn(rstn), .in(in), .out(out_w), .upflow(up_w), .downflow(dn_w));

    function automatic longint sx14(input logic [13:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint sx13(input logic [12:0] v);
        return longint'($signed(v));
    endfunction

    task automatic check(input string tag, input longint got, input longint exp, input longint tol);
        checks++;
        if (got > exp + tol || got < exp - tol) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    task automatic apply(input logic [15:0] v);
        @(negedge clk);
        in = v;
        @(posedge clk);
        #1;
    endtask

    // Hand-computed round(sin(x) * 4096) for the reference configuration
    logic [15:0] dir_in  [7] = '{16'h0000, 16'h1922, 16'hE6DE, 16'h645D, 16'hC31F, 16'h8000, 16'h3244};
    int          dir_exp [7] = '{0,        4096,     -4096,    -43,      2522,     -4052,    0};

    initial begin
        logic [15:0] v;
        real         sref;
        longint      rnd;

        // Asynchronous reset, checked before any clock edge
        #1 rstn = 1'b0;
        #1;
        check("rst_out", longint'(out_r), 0, 0);
        check("rst_up", longint'(up_r), 0, 0);
        check("rst_dn", longint'(dn_r), 0, 0);
        @(negedge clk);
        rstn = 1'b1;

        foreach (dir_in[i]) begin
            apply(dir_in[i]);
            check($sformatf("dir%0d_out", i), sx14(out_r), longint'(dir_exp[i]), 1);
            check($sformatf("dir%0d_flg", i), longint'({up_r, dn_r}), 0, 0);
        end

        // +1.0 is not representable with one integer bit
        apply(16'h1922);
        check("sat_out", longint'(out_s), 13'h0FFF, 0);
        check("sat_up", longint'(up_s), 1, 0);
        check("sat_dn", longint'(dn_s), 0, 0);
        // Low 13 bits of +4096 are 0x1000 (reads back as -1.0)
        check("wrp_out", longint'(out_w), 13'h1000, 0);
        check("wrp_up", longint'(up_w), 1, 0);
        check("wrp_dn", longint'(dn_w), 0, 0);
        // sin just below 1.0 truncates to 4095, never 4096
        check("trn_top", sx14(out_t), 4095, 0);

        // -1.0 is exactly the most negative code: no downflow
        apply(16'hE6DE);
        check("neg1_out", sx13(out_s), -4096, 1);
        check("neg1_up", longint'(up_s), 0, 0);
        check("neg1_dn", longint'(dn_s), 0, 0);

        // Reset asserted between edges while a result is held
        apply(16'h1922);
        @(negedge clk);
        in = 16'h133D;
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_out", longint'(out_r), 0, 0);
        check("mid_rst_flg", longint'({up_s, dn_s}), 0, 0);
        check("mid_rst_sat", longint'(out_s), 0, 0);
        @(posedge clk);
        #1;
        check("hold_rst_out", longint'(out_r), 0, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("rel_out", sx14(out_r), 3821, 1);

        // One new input every cycle, compared against double-precision sin
        for (int i = 0; i < 1000; i++) begin
            v = 16'($urandom);
            apply(v);
            sref = $sin(real'($signed(v)) / 4096.0) * 4096.0;
            rnd  = longint'($floor(sref + 0.5));
            check("rnd_acc", sx14(out_r), rnd, 1);
            check("trn_acc", sx14(out_t), rnd, 1);
            check("trn_ord", longint'(sx14(out_t) <= sx14(out_r) && sx14(out_r) <= sx14(out_t) + 1), 1, 0);
            check("trn_below", longint'(real'(sx14(out_t)) <= sref), 1, 0);
            check("swp_flg", longint'({up_r, dn_r, up_t, dn_t}), 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
